// File: rtl/regfile_2r1w_if.sv
// Decode/write-back/debug signal bundle for the 2-read 1-write register file.
// The master side drives requests and the slave side (the register file) returns data.
interface regfile_2r1w_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic              we_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              re1_i;
  logic [ADDR_W-1:0] raddr1_i;
  logic [DATA_W-1:0] rdata1_o;
  logic              re2_i;
  logic [ADDR_W-1:0] raddr2_i;
  logic [DATA_W-1:0] rdata2_o;
  logic [ADDR_W-1:0] dbg_addr_i;
  logic [DATA_W-1:0] dbg_data_o;
  logic [CNT_W-1:0]  wr_cnt_o;

  modport master (
    output we_i, waddr_i, wdata_i, re1_i, raddr1_i, re2_i, raddr2_i, dbg_addr_i,
    input  rdata1_o, rdata2_o, dbg_data_o, wr_cnt_o
  );
  modport slave (
    input  we_i, waddr_i, wdata_i, re1_i, raddr1_i, re2_i, raddr2_i, dbg_addr_i,
    output rdata1_o, rdata2_o, dbg_data_o, wr_cnt_o
  );
endinterface

// File: rtl/regfile_2r1w.sv
// 32x32 register file: $0 hardwired to zero, two combinational read ports with
// write-through bypass, registered debug read and a retired-write counter.
module regfile_2r1w_rd_lane #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] rdata
);
  // Disabled, reset or $0 reads return 0 so no stale data leaks out.
  always_comb begin
    rdata = '0;
    if (rst && re && (raddr != '0))
      rdata = (we && (waddr == raddr)) ? wdata : mem_data;
  end
endmodule

module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input logic          clk,
  input logic          rst,
  regfile_2r1w_if.slave rf
);
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int NUM_RD = 2;

  logic [DEPTH-1:0][DATA_W-1:0]  mem;
  logic [CNT_W-1:0]              wr_cnt;
  logic [DATA_W-1:0]             dbg_data;
  logic [NUM_RD-1:0]             re;
  logic [NUM_RD-1:0][ADDR_W-1:0] raddr;
  logic [NUM_RD-1:0][DATA_W-1:0] rdata;
  logic                          wr_eff;

  assign re     = {rf.re2_i, rf.re1_i};
  assign raddr  = {rf.raddr2_i, rf.raddr1_i};
  assign wr_eff = rf.we_i && (rf.waddr_i != '0);

  genvar g;
  generate
    for (g = 0; g < NUM_RD; g++) begin : g_rd
      regfile_2r1w_rd_lane #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lane (
        .rst      (rst),
        .re       (re[g]),
        .raddr    (raddr[g]),
        .we       (rf.we_i),
        .waddr    (rf.waddr_i),
        .wdata    (rf.wdata_i),
        .mem_data (mem[raddr[g]]),
        .rdata    (rdata[g])
      );
    end
  endgenerate

  // mem[0] is never written, so it stays at its reset value of 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem      <= '0;
      wr_cnt   <= '0;
      dbg_data <= '0;
    end else begin
      dbg_data <= mem[rf.dbg_addr_i];
      if (wr_eff) begin
        mem[rf.waddr_i] <= rf.wdata_i;
        wr_cnt          <= wr_cnt + CNT_W'(1);
      end
    end
  end

  assign rf.rdata1_o   = rdata[0];
  assign rf.rdata2_o   = rdata[1];
  assign rf.dbg_data_o = dbg_data;
  assign rf.wr_cnt_o   = wr_cnt;
endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench: the driver pushes expected outputs from an array model,
// the monitor pops and compares them on the falling edge.
module tb_regfile_2r1w;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_2r1w_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) rf1 ();
  regfile_2r1w_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  rf2 ();

  regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut  (.clk(clk), .rst(rst), .rf(rf1));
  regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .rf(rf2));

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state
  logic [31:0] model [32];
  longint      cnt_model;
  logic [31:0] dbg_model;

  logic        we_v, re1_v, re2_v;
  logic [4:0]  waddr_v, ra1_v, ra2_v, dbg_v;
  logic [31:0] wdata_v;

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] ra);
    if (!rst || !re || ra == 5'd0) return 32'h0;
    if (we_v && waddr_v == ra) return wdata_v;
    return model[ra];
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    cnt_model = 0;
    dbg_model = 32'h0;
  endfunction

  // Drive one cycle's inputs (called just after a rising edge), queue the
  // expectations, then advance the model across the next rising edge.
  task automatic step(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic re1, input logic [4:0] ra1, input logic re2,
                      input logic [4:0] ra2, input logic [4:0] da, input string tag);
    exp_t e;
    rst = r;
    we_v = we; waddr_v = wa; wdata_v = wd;
    re1_v = re1; ra1_v = ra1; re2_v = re2; ra2_v = ra2; dbg_v = da;
    rf1.we_i = we; rf1.waddr_i = wa; rf1.wdata_i = wd;
    rf1.re1_i = re1; rf1.raddr1_i = ra1; rf1.re2_i = re2; rf1.raddr2_i = ra2; rf1.dbg_addr_i = da;
    rf2.we_i = we; rf2.waddr_i = wa; rf2.wdata_i = wd;
    rf2.re1_i = re1; rf2.raddr1_i = ra1; rf2.re2_i = re2; rf2.raddr2_i = ra2; rf2.dbg_addr_i = da;
    if (!r) clear_model();
    e.name = tag;
    e.kind = 0; e.exp = exp_rd(re1, ra1);                  q.push_back(e);
    e.kind = 1; e.exp = exp_rd(re2, ra2);                  q.push_back(e);
    e.kind = 2; e.exp = dbg_model;                         q.push_back(e);
    e.kind = 3; e.exp = 32'(cnt_model);                    q.push_back(e);
    e.kind = 4; e.exp = 32'(cnt_model % 16);               q.push_back(e);
    @(posedge clk);
    if (rst) begin
      dbg_model = model[da];
      if (we && wa != 5'd0) begin
        model[wa] = wd;
        cnt_model = cnt_model + 1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle_read(input logic [4:0] a, input string tag);
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, a, 1'b1, a, a, tag);
  endtask

  // Monitor: compare everything queued for this cycle on the falling edge.
  initial begin
    exp_t e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.kind)
          0:       act = rf1.rdata1_o;
          1:       act = rf1.rdata2_o;
          2:       act = rf1.dbg_data_o;
          3:       act = rf1.wr_cnt_o;
          default: act = {28'h0, rf2.wr_cnt_o};
        endcase
        n_cmp++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s k%0d cyc=%0d got=%h exp=%h", e.name, e.kind, cyc, act, e.exp);
        end
      end
    end
  end

  initial begin
    clear_model();
    we_v = 0; waddr_v = 0; wdata_v = 0; re1_v = 0; ra1_v = 0; re2_v = 0; ra2_v = 0; dbg_v = 0;
    rf1.we_i = 0; rf1.waddr_i = 0; rf1.wdata_i = 0; rf1.re1_i = 0; rf1.raddr1_i = 0;
    rf1.re2_i = 0; rf1.raddr2_i = 0; rf1.dbg_addr_i = 0;
    rf2.we_i = 0; rf2.waddr_i = 0; rf2.wdata_i = 0; rf2.re1_i = 0; rf2.raddr1_i = 0;
    rf2.re2_i = 0; rf2.raddr2_i = 0; rf2.dbg_addr_i = 0;
    @(posedge clk); #1;

    // Writes held in reset must not land
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b1, 5'd5, 5'd5, "rst_hold");
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b1, 5'd5, 5'd5, "rst_hold");
    idle_read(5'd5, "rst_release");
    idle_read(5'd5, "rst_vals");

    // Basic write/read on both ports
    step(1'b1, 1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3, "wr_r3");
    idle_read(5'd3, "rd_r3");

    // Bypass, then bypass masked by re1=0
    step(1'b1, 1'b1, 5'd7, 32'h00000001, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, "wr_r7");
    step(1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7, "bypass");
    step(1'b1, 1'b1, 5'd7, 32'h0BADF00D, 1'b0, 5'd7, 1'b1, 5'd7, 5'd7, "bypass_re0");
    idle_read(5'd7, "rd_r7");

    // $0 protection, including no bypass at address 0
    step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0, "wr_r0");
    idle_read(5'd0, "rd_r0");

    // Debug latency: old value one cycle after the write edge, new one after
    step(1'b1, 1'b1, 5'd9, 32'h00000055, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9, "dbg_wr");
    idle_read(5'd9, "dbg_old");
    idle_read(5'd9, "dbg_new");

    // Fresh reset, r1..r4 writes, then async reset between edges
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, "rst2");
    for (int i = 1; i <= 4; i++)
      step(1'b1, 1'b1, 5'(i), 32'h1000 + 32'(i), 1'b1, 5'(i), 1'b1, 5'(i - 1), 5'(i), "wr_r1_4");
    idle_read(5'd1, "pre_async");
    step(1'b0, 1'b1, 5'd2, 32'h77, 1'b1, 5'd1, 1'b1, 5'd2, 5'd1, "async_rst");
    idle_read(5'd1, "post_rel");
    idle_read(5'd1, "post_rel_rd");

    // 16 writes to r1 wrap the 4-bit counter back to 0
    for (int i = 0; i < 17; i++)
      step(1'b1, 1'b1, 5'd1, 32'($urandom), 1'b1, 5'd1, 1'b0, 5'd0, 5'd1, "wrap");

    // Random traffic, with address collisions made likely
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa, a1, a2;
      wa = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 99) != 0), 1'($urandom), wa, 32'($urandom),
           ($urandom_range(0, 4) != 0), a1, ($urandom_range(0, 4) != 0), a2,
           5'($urandom_range(0, 31)), "rand");
    end

    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- General-purpose register file for the 5-stage integer pipeline: 32 x 32-bit registers, $0 hardwired to zero.
- Services the two read-request ports driven by the decode stage (enable + 5-bit address per port) with combinational read data.
- Accepts one write per cycle from the write-back stage, with same-cycle write-to-read bypass.
- Adds a debug read port and a retired-write counter for bench and trace use.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- CNT_W, 32, width of the write-event counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- we_i  in  1  write enable from write-back.
- waddr_i  in  ADDR_W  write address.
- wdata_i  in  DATA_W  write data.
- re1_i  in  1  read enable, port 1.
- raddr1_i  in  ADDR_W  read address, port 1.
- rdata1_o  out  DATA_W  read data, port 1.
- re2_i  in  1  read enable, port 2.
- raddr2_i  in  ADDR_W  read address, port 2.
- rdata2_o  out  DATA_W  read data, port 2.
- dbg_addr_i  in  ADDR_W  debug read address.
- dbg_data_o  out  DATA_W  debug read data, registered.
- wr_cnt_o  out  CNT_W  count of architecturally effective writes.

Behaviour:
- Reset (rst=0, async): all 32 registers clear to 0, dbg_data_o=0, wr_cnt_o=0. While rst=0, rdata1_o and rdata2_o are forced to 0 regardless of inputs. Reset asserted mid-cycle clears state immediately, with no wait for clk. Release is sampled on the next rising edge; the first write can land on the first edge after release.
- Write (registered): on a rising edge with rst=1, we_i=1 and waddr_i!=0, reg[waddr_i] <= wdata_i and wr_cnt_o increments by 1. wr_cnt_o wraps modulo 2**CNT_W from all-ones to 0.
- Write to $0 (waddr_i=0, we_i=1): ignored. reg[0] stays 0 and wr_cnt_o does not increment.
- Read port n (combinational, zero latency). Priority, first match wins:
  - rst=0 -> 0.
  - re_n=0 -> 0.
  - raddr_n=0 -> 0.
  - we_i=1 and waddr_i==raddr_n -> wdata_i (write-through bypass; the decode stage sees the value being written back this cycle).
  - otherwise -> reg[raddr_n].
- Both read ports are independent. Same address on both ports returns identical data, including the bypass case.
- Debug port:
  - dbg_data_o <= reg[dbg_addr_i] on each rising edge, so data appears 1 cycle after the address.
  - No bypass: a write on edge k to address A with dbg_addr_i=A returns the old value at k+1 and the new value at k+2.
  - dbg_addr_i=0 returns 0.
- No X propagation: unread ports output 0, never stale data.
- Arithmetic: the only arithmetic is the wr_cnt_o unsigned increment. No sign handling anywhere.

Test Plan:
- Reset values: hold rst=0, toggle clk with we_i=1 waddr=5 wdata=0xDEADBEEF -> release, read raddr1=5 re1=1 gives 0x00000000; wr_cnt_o=0.
- Basic write/read: write 0x12345678 to r3 on one edge -> next cycle re1=1 raddr1=3 gives 0x12345678, re2=1 raddr2=3 gives the same; wr_cnt_o=1.
- Bypass: r7 holds 0x1; same cycle drive we_i=1 waddr=7 wdata=0xA5A5A5A5 with raddr1=7 re1=1 -> rdata1_o=0xA5A5A5A5 before the edge. With re1=0 -> rdata1_o=0.
- $0 protection: write 0xFFFFFFFF to r0 -> rdata1 at raddr 0 is 0, dbg at 0 is 0, wr_cnt_o unchanged. Bypass does not apply to address 0.
- Debug latency: write 0x55 to r9 at edge k with dbg_addr=9 -> dbg_data_o=old value (0) after k, 0x55 after k+1.
- Async reset mid-run: after writes to r1..r4 (wr_cnt_o=4), pull rst low between edges -> all reads, dbg_data_o and wr_cnt_o go 0 immediately. After release, r1 reads 0.
- Counter wrap (CNT_W=4 build): 16 writes to r1 -> wr_cnt_o returns to 0.
